// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//
// Purpose:
//   Turns an already-debounced, clk-synchronous button level into single-cycle
//   gesture events: press/release edges, short press, long press and double
//   press. It sits right after the button debouncer and feeds control logic
//   that wants events rather than levels. Every output is registered.
//
// Parameters:
//   LONG_CYCLES  cycles the first press must be held before long_press (>=2)
//   DOUBLE_GAP   max cycles released between presses to count as double (>=2)
//   CNT_W        timer width, 2**CNT_W > max(LONG_CYCLES, DOUBLE_GAP)
//
// Ports:
//   clk              in   1  system clock, everything on posedge
//   rst              in   1  asynchronous, active-high reset
//   btn_i            in   1  debounced button level, 1 = pressed
//   press_pulse_o    out  1  one-cycle pulse after a 0->1 edge of btn_i
//   release_pulse_o  out  1  one-cycle pulse after a 1->0 edge of btn_i
//   short_press_o    out  1  one-cycle pulse: press+release, no second press
//                            within the gap
//   long_press_o     out  1  one-cycle pulse: first press held LONG_CYCLES
//   double_press_o   out  1  one-cycle pulse: second press began within the gap
//   busy_o           out  1  high whenever the gesture FSM is not idle
//   event_count_o    out  8  running count of short+long+double, wraps
// -----------------------------------------------------------------------------
module button_event_decoder #(
    parameter int LONG_CYCLES = 50,
    parameter int DOUBLE_GAP  = 25,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_i,
    output logic       press_pulse_o,
    output logic       release_pulse_o,
    output logic       short_press_o,
    output logic       long_press_o,
    output logic       double_press_o,
    output logic       busy_o,
    output logic [7:0] event_count_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRESS1    = 3'd1,
        S_WAIT2     = 3'd2,
        S_PRESS2    = 3'd3,
        S_LONG_HOLD = 3'd4
    } state_t;

    // Terminal timer values: the timer counts 0..N-1 inside a state, so the
    // decision is taken on the edge where it already holds N-1.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_GAP - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             btn_q;
    logic             rel_arm_q, rel_arm_d;
    logic             press_q, release_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             busy_q, busy_d;
    logic [7:0]       count_q, count_d;

    logic rise;
    logic fall;

    // btn_q resets to 1 so that a button held through reset cannot look like
    // a fresh press; only a genuine 0->1 after reset is a rise.
    assign rise = btn_i & ~btn_q;
    assign fall = ~btn_i & btn_q;

    // The forced btn_q=1 after reset would make the first low sample look
    // like a release. rel_arm_q stays clear until the button has been seen
    // low once, which swallows exactly that artificial edge.
    assign rel_arm_d = rel_arm_q | ~btn_i;

    // ------------------------------------------------------------------
    // Process 1: state register (plus all other registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            btn_q     <= 1'b1;
            rel_arm_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            double_q  <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            btn_q     <= btn_i;
            rel_arm_q <= rel_arm_d;
            press_q   <= rise;
            release_q <= fall & rel_arm_q;
            short_q   <= short_d;
            long_q    <= long_d;
            double_q  <= double_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state and timer. The timer is cleared on every state
    // entry; it only advances while a state is waiting for its deadline.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS1;
                    timer_d = '0;
                end
            end
            S_PRESS1: begin
                // A release on the deadline edge still counts as a release.
                if (!btn_i) begin
                    state_d = S_WAIT2;
                    timer_d = '0;
                end else if (timer_q == LONG_LAST) begin
                    state_d = S_LONG_HOLD;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_WAIT2: begin
                // A second press on the deadline edge still makes a double.
                if (btn_i) begin
                    state_d = S_PRESS2;
                    timer_d = '0;
                end else if (timer_q == DOUBLE_LAST) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_PRESS2, S_LONG_HOLD: begin
                // Nothing more is reported until the button is let go.
                if (!btn_i) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: event outputs. The three gesture conditions are mutually
    // exclusive because they depend on distinct states / btn values.
    // ------------------------------------------------------------------
    always_comb begin
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            S_PRESS1: long_d   = btn_i && (timer_q == LONG_LAST);
            S_WAIT2: begin
                double_d = btn_i;
                short_d  = !btn_i && (timer_q == DOUBLE_LAST);
            end
            default: ;
        endcase

        // busy follows the state being entered, so it rises together with
        // the departure from idle rather than one cycle later.
        busy_d  = (state_d != S_IDLE);
        count_d = (short_d | long_d | double_d) ? count_q + 8'd1 : count_q;
    end

    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign short_press_o   = short_q;
    assign long_press_o    = long_q;
    assign double_press_o  = double_q;
    assign busy_o          = busy_q;
    assign event_count_o   = count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;

    localparam int LC = 50;
    localparam int DG = 25;

    // event kinds encoded as cycle*8 + kind
    localparam int K_PRESS   = 1;
    localparam int K_RELEASE = 2;
    localparam int K_SHORT   = 3;
    localparam int K_LONG    = 4;
    localparam int K_DOUBLE  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       press_pulse, release_pulse, short_press, long_press, double_press, busy;
    logic [7:0] event_count;

    button_event_decoder #(
        .LONG_CYCLES(LC),
        .DOUBLE_GAP (DG),
        .CNT_W      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_i          (btn),
        .press_pulse_o  (press_pulse),
        .release_pulse_o(release_pulse),
        .short_press_o  (short_press),
        .long_press_o   (long_press),
        .double_press_o (double_press),
        .busy_o         (busy),
        .event_count_o  (event_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_q[$];
    int obs_q[$];
    int checks = 0;
    int errors = 0;

    // bench model of the gesture sequence
    int m_mode  = 0;   // 0: next press is a first press, 1: in gap after a first press, 2: second press
    int w_rel   = 0;   // cycle of the first press's release edge
    int m_count = 0;

    // Monitor: record every pulse seen, tagged with the edge that produced it.
    always @(negedge clk) begin
        if (!rst) begin
            if (press_pulse)   obs_q.push_back(cyc * 8 + K_PRESS);
            if (release_pulse) obs_q.push_back(cyc * 8 + K_RELEASE);
            if (short_press)   obs_q.push_back(cyc * 8 + K_SHORT);
            if (long_press)    obs_q.push_back(cyc * 8 + K_LONG);
            if (double_press)  obs_q.push_back(cyc * 8 + K_DOUBLE);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press for h cycles then release for g cycles; push the expected events.
    task automatic gesture(input int h, input int g);
        int p;
        p = cyc + 1;                        // edge that samples btn=1
        if (m_mode == 1) begin
            if (p - w_rel <= DG) begin
                exp_q.push_back(p * 8 + K_PRESS);
                exp_q.push_back(p * 8 + K_DOUBLE);
                m_count++;
                m_mode = 2;
            end else begin
                exp_q.push_back((w_rel + DG) * 8 + K_SHORT);
                m_count++;
                exp_q.push_back(p * 8 + K_PRESS);
                m_mode = 0;
            end
        end else begin
            exp_q.push_back(p * 8 + K_PRESS);
        end
        if (m_mode == 2) begin
            exp_q.push_back((p + h) * 8 + K_RELEASE);
            m_mode = 0;
        end else if (h > LC) begin
            exp_q.push_back((p + LC) * 8 + K_LONG);
            m_count++;
            exp_q.push_back((p + h) * 8 + K_RELEASE);
            m_mode = 0;
        end else begin
            exp_q.push_back((p + h) * 8 + K_RELEASE);
            m_mode = 1;
            w_rel  = p + h;
        end
        btn = 1'b1;
        step(h);
        btn = 1'b0;
        step(g);
    endtask

    // Let a pending short press expire.
    task automatic flush();
        if (m_mode == 1) begin
            if (cyc < w_rel + DG + 1) step(w_rel + DG + 1 - cyc);
            exp_q.push_back((w_rel + DG) * 8 + K_SHORT);
            m_count++;
            m_mode = 0;
        end
        step(3);
    endtask

    task automatic model_reset();
        exp_q.delete();
        obs_q.delete();
        m_mode  = 0;
        m_count = 0;
    endtask

    task automatic test_reset();
        int e, o;
        rst = 1'b1;
        btn = 1'b0;
        step(3);
        checks++;
        if ({press_pulse, release_pulse, short_press, long_press, double_press, busy, event_count} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {press_pulse, release_pulse, short_press, long_press, double_press, busy, event_count});
        end
        rst = 1'b0;
        model_reset();
        step(5);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_events: got cyc %0d kind %0d want cyc %0d kind %0d", o / 8, o % 8, e / 8, e % 8);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_short();
        int e, o;
        gesture(10, 40);
        flush();
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL short_events: got cyc %0d kind %0d want cyc %0d kind %0d", o / 8, o % 8, e / 8, e % 8);
            end
        end
        checks++;
        if (event_count !== 8'(m_count)) begin
            errors++;
            $display("FAIL short_count: got %0d want %0d", event_count, 8'(m_count));
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL short_busy: got %b want 0", busy);
        end
        $display("test_short done, event_count=%0d", event_count);
    endtask

    task automatic test_long();
        int e, o;
        btn = 1'b1;
        gesture(60, 10);
        flush();
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL long_events: got cyc %0d kind %0d want cyc %0d kind %0d", o / 8, o % 8, e / 8, e % 8);
            end
        end
        checks++;
        if (event_count !== 8'(m_count)) begin
            errors++;
            $display("FAIL long_count: got %0d want %0d", event_count, 8'(m_count));
        end
        $display("test_long done, event_count=%0d", event_count);
    endtask

    task automatic test_double();
        int e, o;
        gesture(5, 10);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL double_busy_gap: got %b want 1", busy);
        end
        gesture(5, 40);
        flush();
        // gap one longer than allowed: short, then a fresh first press
        gesture(5, DG + 1);
        gesture(5, 40);
        flush();
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL double_events: got cyc %0d kind %0d want cyc %0d kind %0d", o / 8, o % 8, e / 8, e % 8);
            end
        end
        checks++;
        if (event_count !== 8'(m_count)) begin
            errors++;
            $display("FAIL double_count: got %0d want %0d", event_count, 8'(m_count));
        end
        $display("test_double done, event_count=%0d", event_count);
    endtask

    task automatic test_boundary();
        int e, o;
        gesture(LC, DG);        // release at timer==LC-1, re-press at timer==DG-1
        gesture(5, 40);
        flush();
        gesture(LC + 1, 10);    // one cycle longer: long press
        flush();
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL boundary_events: got cyc %0d kind %0d want cyc %0d kind %0d", o / 8, o % 8, e / 8, e % 8);
            end
        end
        checks++;
        if (event_count !== 8'(m_count)) begin
            errors++;
            $display("FAIL boundary_count: got %0d want %0d", event_count, 8'(m_count));
        end
        $display("test_boundary done, event_count=%0d", event_count);
    endtask

    task automatic test_reset_cases();
        int e, o, p;
        // button held across reset release
        rst = 1'b1;
        btn = 1'b1;
        step(2);
        rst = 1'b0;
        model_reset();
        step(10);
        btn = 1'b0;
        step(40);
        // reset in the middle of a first press
        p = cyc + 1;
        exp_q.push_back(p * 8 + K_PRESS);
        btn = 1'b1;
        step(10);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({press_pulse, release_pulse, short_press, long_press, double_press, busy, event_count} !== 14'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got %b want all zero",
                     {press_pulse, release_pulse, short_press, long_press, double_press, busy, event_count});
        end
        step(2);
        rst = 1'b0;
        m_mode  = 0;
        m_count = 0;
        step(LC + 10);
        btn = 1'b0;
        step(40);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstcase_events: got cyc %0d kind %0d want cyc %0d kind %0d", o / 8, o % 8, e / 8, e % 8);
            end
        end
        checks++;
        if (event_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstcase_idle: got count %0d busy %b want count 0 busy 0", event_count, busy);
        end
        $display("test_reset_cases done at cycle %0d", cyc);
    endtask

    task automatic test_back_to_back();
        int e, o;
        for (int i = 0; i < 256; i++) gesture(2, DG + 2);
        flush();
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_events: got cyc %0d kind %0d want cyc %0d kind %0d", o / 8, o % 8, e / 8, e % 8);
            end
        end
        checks++;
        if (event_count !== 8'(m_count)) begin
            errors++;
            $display("FAIL b2b_count_wrap: got %0d want %0d (events %0d)", event_count, 8'(m_count), m_count);
        end
        $display("test_back_to_back done, %0d events, event_count=%0d", m_count, event_count);
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_double();
        test_boundary();
        test_reset_cases();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
